// File: rtl/keycode_event_gen.sv
// keycode_event_gen: turns keycode level changes into PRESS/REPEAT/RELEASE events queued in a FWFT FIFO.
// Define KEYCODE_REPEAT_EN for typematic auto-repeat; without it only PRESS/RELEASE are produced.
module keycode_event_gen #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic [1:0] evt_type,
    output logic       held,
    output logic       overflow,
    input  logic       clr_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] EV_PRESS = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b10;

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("keycode_event_gen: invalid parameters");
    end

`ifdef KEYCODE_REPEAT_EN
    localparam int MAXC = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [1:0] EV_REPEAT = 2'b01;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    logic [CW-1:0] cnt;
`else
    typedef enum logic {IDLE, HELD} state_t;
`endif

    state_t        state;
    logic [7:0]    cur;
    logic          push, pop, wr_en, drop;
    logic [9:0]    push_evt;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    // state != IDLE exactly when cur != 0; a changed key always releases first
    always_comb begin
        push = 1'b0;
        push_evt = {EV_PRESS, keycode};
        if (state != IDLE && keycode != cur) begin
            push = 1'b1;
            push_evt = {EV_RELEASE, cur};
        end else if (state == IDLE && keycode != 8'h00) begin
            push = 1'b1;
`ifdef KEYCODE_REPEAT_EN
        end else if (state != IDLE && cnt == '0) begin
            push = 1'b1;
            push_evt = {EV_REPEAT, cur};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cur <= '0;
`ifdef KEYCODE_REPEAT_EN
            cnt <= '0;
`endif
        end else if (state != IDLE && keycode != cur) begin
            state <= IDLE;
            cur <= '0;
        end else if (state == IDLE && keycode != 8'h00) begin
            cur <= keycode;
`ifdef KEYCODE_REPEAT_EN
            state <= DELAY;
            cnt <= CW'(REPEAT_DELAY - 1);
        end else if (state != IDLE) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                cnt <= CW'(REPEAT_RATE - 1);
                state <= REPEAT;
            end
`else
            state <= HELD;
`endif
        end
    end

    assign evt_valid = count != '0;
    assign pop = evt_valid & evt_ready;
    assign wr_en = push & (count != DEPTH | pop);
    assign drop = push & ~wr_en;
    assign {evt_type, evt_code} = evt_valid ? mem[rd_ptr] : 10'h000;
    assign held = cur != 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_evt;
    end

    // drop sets overflow ahead of a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (drop) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keycode_event_gen.sv
// tb_keycode_event_gen: directed stimulus with a scoreboard queue checked by an independent monitor.
module tb_keycode_event_gen;
    localparam int RD = 10;
    localparam int RR = 4;
    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_REPEAT = 2'b01;
    localparam logic [1:0] T_RELEASE = 2'b10;

    typedef struct {
        logic [7:0] code;
        logic [1:0] typ;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n, evt_valid, evt_ready, held, overflow, clr_overflow;
    logic [7:0] keycode, evt_code;
    logic [1:0] evt_type;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    ev_t        exp_q[$];

    keycode_event_gen #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .keycode(keycode),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_type(evt_type),
        .held(held),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // cyc = -1 means "order only"; otherwise the cycle in which the event must be at the head
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset_n && evt_valid && evt_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got code=%h type=%b at cyc %0d, none expected", evt_code, evt_type, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (evt_code !== e.code || evt_type !== e.typ || (e.cyc >= 0 && cyc != e.cyc)) begin
                        fails++;
                        $display("FAIL event: got code=%h type=%b cyc=%0d, expected code=%h type=%b cyc=%0d",
                                 evt_code, evt_type, cyc, e.code, e.typ, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ev(input logic [7:0] code, input logic [1:0] typ, input int c);
        ev_t e;
        e.code = code;
        e.typ = typ;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d events still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        step(1);
        check("drain_empty", {7'd0, evt_valid}, 8'd0);
    endtask

    // hold a key for h cycles then release; repeats land RD, RD+RR, ... edges after the PRESS edge
    task automatic hold_key(input logic [7:0] code, input int h);
        int n = cyc;
        keycode = code;
        exp_ev(code, T_PRESS, n + 1);
`ifdef KEYCODE_REPEAT_EN
        for (int k = 0; RD + RR * k < h; k++) exp_ev(code, T_REPEAT, n + 1 + RD + RR * k);
`endif
        step(1);
        check("hold_held_on", {7'd0, held}, 8'd1);
        step(h - 1);
        keycode = 8'h00;
        exp_ev(code, T_RELEASE, n + h + 1);
        step(1);
        check("hold_held_off", {7'd0, held}, 8'd0);
        drain(20);
    endtask

    initial begin
        reset_n = 1'b0;
        keycode = 8'h00;
        evt_ready = 1'b1;
        clr_overflow = 1'b0;
        step(2);
        check("rst_valid", {7'd0, evt_valid}, 8'd0);
        check("rst_code", evt_code, 8'h00);
        check("rst_type", {6'd0, evt_type}, 8'd0);
        check("rst_held", {7'd0, held}, 8'd0);
        check("rst_ovf", {7'd0, overflow}, 8'd0);
        reset_n = 1'b1;
        step(2);

        hold_key(8'h1A, 30);

        keycode = 8'h04;
        exp_ev(8'h04, T_PRESS, cyc + 1);
        step(3);
        keycode = 8'h07;
        exp_ev(8'h04, T_RELEASE, cyc + 1);
        exp_ev(8'h07, T_PRESS, cyc + 2);
        step(1);
        check("chg_held_gap", {7'd0, held}, 8'd0);
        step(1);
        check("chg_held_b", {7'd0, held}, 8'd1);
        keycode = 8'h00;
        exp_ev(8'h07, T_RELEASE, cyc + 1);
        step(1);
        drain(10);

        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keycode = (i % 2 == 0) ? 8'h04 : 8'h00;
            if (i < 4) exp_ev(8'h04, (i % 2 == 0) ? T_PRESS : T_RELEASE, -1);
            step(1);
            if (i == 3) check("ovf_full_no_drop", {7'd0, overflow}, 8'd0);
        end
        check("ovf_set", {7'd0, overflow}, 8'd1);
        keycode = 8'h00;
        clr_overflow = 1'b1;
        step(1);
        check("ovf_set_wins", {7'd0, overflow}, 8'd1);
        step(1);
        check("ovf_clr", {7'd0, overflow}, 8'd0);
        clr_overflow = 1'b0;
        check("ovf_valid", {7'd0, evt_valid}, 8'd1);
        evt_ready = 1'b1;
        drain(20);

        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            keycode = (i % 2 == 0) ? 8'h04 : 8'h00;
            exp_ev(8'h04, (i % 2 == 0) ? T_PRESS : T_RELEASE, -1);
            step(1);
        end
        keycode = 8'h04;
        evt_ready = 1'b1;
        exp_ev(8'h04, T_PRESS, -1);
        step(1);
        evt_ready = 1'b0;
        check("full_pp_ovf", {7'd0, overflow}, 8'd0);
        keycode = 8'h00;
        step(1);
        check("full_pp_still_full", {7'd0, overflow}, 8'd1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        evt_ready = 1'b1;
        drain(20);

        evt_ready = 1'b0;
        keycode = 8'h1A;
        step(1);
        keycode = 8'h00;
        step(1);
        keycode = 8'h1A;
        step(1);
        check("pre_rst_valid", {7'd0, evt_valid}, 8'd1);
        reset_n = 1'b0;
        exp_q.delete();
        step(1);
        check("mid_rst_valid", {7'd0, evt_valid}, 8'd0);
        check("mid_rst_code", evt_code, 8'h00);
        check("mid_rst_type", {6'd0, evt_type}, 8'd0);
        check("mid_rst_held", {7'd0, held}, 8'd0);
        check("mid_rst_ovf", {7'd0, overflow}, 8'd0);
        reset_n = 1'b1;
        evt_ready = 1'b1;
        exp_ev(8'h1A, T_PRESS, cyc + 1);
        step(2);
        keycode = 8'h00;
        exp_ev(8'h1A, T_RELEASE, cyc + 1);
        step(1);
        drain(10);

        hold_key(8'h2C, 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
